// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue_pkg : shared widths, request FSM states, helpers      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  localparam logic [RISCV_ADDR_WIDTH-1:0] FQ_WORD_BYTES = RISCV_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    FQ_IDLE     = 2'd0,
    FQ_REQ      = 2'd1,
    FQ_REQ_KILL = 2'd2
  } fq_state_e;

  function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(
    input logic [RISCV_ADDR_WIDTH-1:0] addr
  );
    return addr & {{(RISCV_ADDR_WIDTH-2){1'b1}}, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry circular buffer of {address, word}       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  input  logic                      clear,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]        r_head;
  logic [PW:0]        r_tail;
  logic [AW+DW-1:0]   r_mem [DEPTH];
  logic [AW+DW-1:0]   w_head_entry;

  // Extra wrap bit on each pointer lets tail - head span 0..DEPTH
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_tail[PW-1:0]] <= {push_addr, push_data};
  end

  assign count        = r_tail - r_head;
  assign empty        = (count == '0);
  assign w_head_entry = r_mem[r_head[PW-1:0]];
  assign head_addr    = empty ? '0 : w_head_entry[AW+DW-1:DW];
  assign head_data    = empty ? '0 : w_head_entry[DW-1:0];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue : prefetching instruction fetch unit with redirects   |
// | Optional FETCH_PERF_EN enables fetched/flushed/stall counters.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDRESS = '0,
  parameter int                          DEPTH        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RISCV_ADDR_WIDTH-1:0]   target_addr_i,
  input  logic                          target_valid_i,
  input  logic                          retire_inst_i,
  output logic [RISCV_WORD_WIDTH-1:0]   instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0]   instr_addr_o,
  output logic                          instr_valid_o,
  output logic                          imem_valid_o,
  input  logic                          imem_ready_i,
  input  logic [RISCV_WORD_WIDTH-1:0]   imem_rdata_i,
  output logic [RISCV_ADDR_WIDTH-1:0]   imem_addr_o,
  output logic [31:0]                   imem_wdata_o,
  output logic [3:0]                    imem_we_o,
  output logic [31:0]                   perf_fetched_o,
  output logic [31:0]                   perf_flushed_o,
  output logic [31:0]                   perf_stall_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e                    r_state;
  fq_state_e                    w_state_next;
  logic [RISCV_ADDR_WIDTH-1:0]  r_pc;
  logic [RISCV_ADDR_WIDTH-1:0]  r_req_addr;
  logic [RISCV_ADDR_WIDTH-1:0]  w_target;
  logic [RISCV_ADDR_WIDTH-1:0]  w_issue_pc;
  logic                         w_xfer;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_issue;
  logic                         w_room;
  logic                         w_empty;
  logic [CW-1:0]                w_count;
  logic [CW-1:0]                w_count_next;

  assign imem_valid_o = (r_state != FQ_IDLE);
  assign imem_addr_o  = r_req_addr;
  assign imem_wdata_o = '0;
  assign imem_we_o    = '0;

  assign w_xfer     = imem_valid_o && imem_ready_i;
  assign w_target   = word_align(target_addr_i);
  assign w_issue_pc = target_valid_i ? w_target : r_pc;

  // A redirect overrides both the incoming response and a same-cycle retire
  assign w_push = w_xfer && (r_state == FQ_REQ) && !target_valid_i;
  assign w_pop  = retire_inst_i && !w_empty && !target_valid_i;

  always_comb begin
    w_count_next = w_count;
    if (target_valid_i) w_count_next = '0;
    else                w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  end

  assign w_room = (w_count_next < CW'(DEPTH));

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      FQ_IDLE: begin
        if (w_room) begin
          w_state_next = FQ_REQ;
          w_issue      = 1'b1;
        end
      end
      FQ_REQ: begin
        if (w_xfer) begin
          if (w_room) begin
            w_state_next = FQ_REQ;
            w_issue      = 1'b1;
          end else begin
            w_state_next = FQ_IDLE;
          end
        end else if (target_valid_i) begin
          w_state_next = FQ_REQ_KILL;
        end
      end
      FQ_REQ_KILL: begin
        // Queue is empty while a killed request drains, so there is always room
        if (w_xfer) begin
          w_state_next = FQ_REQ;
          w_issue      = 1'b1;
        end
      end
      default: w_state_next = FQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FQ_IDLE;
      r_pc       <= BOOT_ADDRESS;
      r_req_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_req_addr <= w_issue_pc;
        r_pc       <= w_issue_pc + FQ_WORD_BYTES;
      end else if (target_valid_i) begin
        r_pc <= w_target;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (RISCV_ADDR_WIDTH),
    .DW    (RISCV_WORD_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_addr (r_req_addr),
    .push_data (imem_rdata_i),
    .pop       (w_pop),
    .clear     (target_valid_i),
    .empty     (w_empty),
    .count     (w_count),
    .head_addr (instr_addr_o),
    .head_data (instr_o)
  );

  assign instr_valid_o = !w_empty;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_stall;
  logic        w_drop_xfer;
  logic [31:0] w_flush_inc;

  assign w_drop_xfer = w_xfer && ((r_state == FQ_REQ_KILL) || target_valid_i);
  assign w_flush_inc = (target_valid_i ? 32'(w_count) : 32'd0) + 32'(w_drop_xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_push);
      r_perf_flushed <= r_perf_flushed + w_flush_inc;
      r_perf_stall   <= r_perf_stall + 32'(w_empty);
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_flushed_o = r_perf_flushed;
  assign perf_stall_o   = r_perf_stall;
`else
  assign perf_fetched_o = '0;
  assign perf_flushed_o = '0;
  assign perf_stall_o   = '0;
`endif

endmodule
`default_nettype wire
